// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per ADD cycle, LSD first.
// IDLE -> ADD (NDIG cycles) -> DONE (one-cycle done pulse) -> IDLE.
module bcd_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a_bcd,
    input  logic [4*NDIG-1:0] b_bcd,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum_bcd,
    output logic              cout,
    output logic              err
);
    localparam int W  = 4 * NDIG;
    localparam int IW = $clog2(NDIG);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            r_err;
    logic            r_busy;
    logic            r_done;

    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [4:0]      w_t;
    logic [4:0]      w_t6;
    logic            w_gt9;
    logic [3:0]      w_dig;
    logic            w_last;
    logic            w_in_err;

    always_comb begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_dig = r_a[4*k +: 4];
                w_b_dig = r_b[4*k +: 4];
            end
        end
    end

    // Decimal adjust: any 5-bit sum above 9 (including invalid digits) wraps by +6.
    assign w_t    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};
    assign w_gt9  = (w_t > 5'd9);
    assign w_t6   = w_t + 5'd6;
    assign w_dig  = w_gt9 ? w_t6[3:0] : w_t[3:0];
    assign w_last = (r_idx == IW'(NDIG - 1));

    always_comb begin
        w_in_err = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (a_bcd[4*k +: 4] > 4'd9 || b_bcd[4*k +: 4] > 4'd9)
                w_in_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_bcd;
                        r_b     <= b_bcd;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= w_in_err;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    for (int k = 0; k < NDIG; k++) begin
                        if (r_idx == IW'(k))
                            r_sum[4*k +: 4] <= w_dig;
                    end
                    r_carry <= w_gt9;
                    if (w_last) begin
                        r_cout  <= w_gt9;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_bcd = r_sum;
    assign cout    = r_cout;
    assign err     = r_err;
endmodule
